// File: rtl/disp_scan_if.sv
// Display-side bundle for the scan driver: glyph/mask/brightness inputs
// from the time/edit logic and the decoder/anode outputs.
interface disp_scan_if #(
    parameter int NDIG = 8
);
    logic [4*NDIG-1:0] digits_i;
    logic [NDIG-1:0]   sep_mask;
    logic [NDIG-1:0]   blink_mask;
    logic              blink_all;
    logic [3:0]        bright;
    logic [3:0]        digit_o;
    logic [NDIG-1:0]   an_o;
    logic              frame_o;
    logic              blink_phase_o;

    // Time/edit logic side: drives the display request, observes the scan.
    modport master (
        output digits_i, sep_mask, blink_mask, blink_all, bright,
        input  digit_o, an_o, frame_o, blink_phase_o
    );

    // Scan driver side.
    modport slave (
        input  digits_i, sep_mask, blink_mask, blink_all, bright,
        output digit_o, an_o, frame_o, blink_phase_o
    );
endinterface

// File: rtl/disp_scan_gen.sv
// Multiplexed seven-segment scan driver: frame-synchronous input shadowing,
// per-digit / whole-display blink, separator forcing and 16-level PWM
// brightness inside every digit slot. All outputs are registered.
module disp_scan_gen #(
    parameter int NDIG         = 8,
    parameter int SLOT_STEP    = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    disp_scan_if.slave   bus
);
    localparam int SW = (SLOT_STEP > 1) ? $clog2(SLOT_STEP) : 1;
    localparam int KW = $clog2(NDIG);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0] S_LAST = SW'(SLOT_STEP - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

    // Scan counters: step within brightness step, duty step, digit slot.
    logic [SW-1:0] s_reg;
    logic [3:0]    d_reg;
    logic [KW-1:0] k_reg;
    logic [BW-1:0] b_reg;
    logic          phase_reg;

    // Shadow copies of the display request, refreshed once per frame.
    logic [4*NDIG-1:0] sh_digits_reg;
    logic [NDIG-1:0]   sh_sep_reg;
    logic [NDIG-1:0]   sh_blink_reg;
    logic              sh_blink_all_reg;
    logic [3:0]        sh_bright_reg;

    // Output registers plus the one-cycle delay that lines frame_o up
    // with the first output cycle of slot 0.
    logic [3:0]      digit_reg;
    logic [NDIG-1:0] an_reg;
    logic            fb_dly_reg;
    logic            frame_reg;
    logic            phase_out_reg;

    logic            s_wrap;
    logic            fb;
    logic [3:0]      pos_code [NDIG];
    logic [3:0]      code_next;
    logic [NDIG-1:0] an_next;

    assign s_wrap = (s_reg == S_LAST);
    assign fb     = s_wrap && (d_reg == 4'hF) && (k_reg == K_LAST);

    // Per-position code with separator > blink > digit priority, and the
    // PWM-gated one-hot enable for the active slot.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_pos
            assign pos_code[gi] =
                sh_sep_reg[gi] ? 4'hB :
                (phase_reg && (sh_blink_all_reg || sh_blink_reg[gi])) ? 4'hF :
                sh_digits_reg[4*gi +: 4];
            assign an_next[gi] = (k_reg == KW'(gi)) && (d_reg <= sh_bright_reg);
        end
    endgenerate

    assign code_next = pos_code[k_reg];

    // Step / duty / slot counters; duty rolls over naturally at 4 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg <= '0;
            d_reg <= '0;
            k_reg <= '0;
        end else if (s_wrap) begin
            s_reg <= '0;
            d_reg <= d_reg + 4'd1;
            if (d_reg == 4'hF)
                k_reg <= (k_reg == K_LAST) ? '0 : k_reg + KW'(1);
        end else begin
            s_reg <= s_reg + SW'(1);
        end
    end

    // Capture the live display request at each frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits_reg    <= '1;
            sh_sep_reg       <= '0;
            sh_blink_reg     <= '0;
            sh_blink_all_reg <= 1'b0;
            sh_bright_reg    <= 4'hF;
        end else if (fb) begin
            sh_digits_reg    <= bus.digits_i;
            sh_sep_reg       <= bus.sep_mask;
            sh_blink_reg     <= bus.blink_mask;
            sh_blink_all_reg <= bus.blink_all;
            sh_bright_reg    <= bus.bright;
        end
    end

    // Blink frame counter; phase flips every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_reg     <= '0;
            phase_reg <= 1'b0;
        end else if (fb) begin
            if (b_reg == B_LAST) begin
                b_reg     <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                b_reg <= b_reg + BW'(1);
            end
        end
    end

    // Register the outputs from the current counter/shadow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_reg     <= 4'hF;
            an_reg        <= '0;
            fb_dly_reg    <= 1'b0;
            frame_reg     <= 1'b0;
            phase_out_reg <= 1'b0;
        end else begin
            digit_reg     <= code_next;
            an_reg        <= an_next;
            fb_dly_reg    <= fb;
            frame_reg     <= fb_dly_reg;
            phase_out_reg <= phase_reg;
        end
    end

    assign bus.digit_o       = digit_reg;
    assign bus.an_o          = an_reg;
    assign bus.frame_o       = frame_reg;
    assign bus.blink_phase_o = phase_out_reg;
endmodule

// File: doc/disp_scan_gen.md
# disp_scan_gen

Parametrised multiplexed seven-segment scan driver for the clock/countdown display path; the next generation of the fixed 8-digit scanner. It time-multiplexes NDIG BCD/glyph codes onto one shared decoder input with a one-hot digit enable. It adds:
- frame-synchronous shadowing of all display inputs, so no frame tears;
- per-digit and whole-display blink;
- per-position separator forcing;
- 16-level brightness PWM within each digit slot.

It sits between the time/edit logic and the segment decoder/anode pins.

## Interface
- NDIG, 8: number of digit positions (2..16).
- SLOT_STEP, 1024: clk cycles per brightness step; one digit slot = 16*SLOT_STEP cycles.
- BLINK_FRAMES, 64: full scan frames per blink half-period (>=1).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- digits_i  in  4*NDIG  glyph codes; position i = bits [4i+3:4i].
- sep_mask  in  NDIG  1 forces position i to separator code 4'hB.
- blink_mask  in  NDIG  1 blinks position i (edit-field blink).
- blink_all  in  1  blinks every non-separator position (alarm/finish).
- bright  in  4  brightness: enable duty = (bright+1)/16 of each slot.
- digit_o  out  4  code for the currently enabled position.
- an_o  out  NDIG  one-hot digit enable, active high.
- frame_o  out  1  one-cycle pulse at each frame boundary.
- blink_phase_o  out  1  current blink phase; 1 = blanked half.

## Operation
- Counters:
  - step counter s: 0..SLOT_STEP-1.
  - duty counter d: 0..15; advances when s wraps.
  - slot counter k: 0..NDIG-1; advances when d wraps from 15, and itself wraps to 0.
- Frame boundary (fb): cycle where s=SLOT_STEP-1, d=15 and k=NDIG-1.
- On the fb edge, the shadow registers load the live digits_i, sep_mask, blink_mask, blink_all and bright. All display decisions use shadow values only. Input changes mid-frame have no visible effect until the next frame.
- Blink counter b: 0..BLINK_FRAMES-1, increments on each fb. When b wraps, blink_phase toggles.
- Code selection for position k, in priority order:
  1. Shadow sep_mask[k]=1 -> 4'hB. Separators never blink.
  2. Else blink_phase=1 and (shadow blink_all or shadow blink_mask[k]) -> 4'hF (blank).
  3. Else shadow digit k.
- Enable: an_o = one-hot(k) when d <= shadow bright; else all zeros. digit_o is driven regardless of enable.
- Reset values:
  - all counters 0; blink_phase 0;
  - shadow digits all 4'hF; shadow masks 0; shadow blink_all 0; shadow bright 4'hF;
  - digit_o=4'hF, an_o=0, frame_o=0, blink_phase_o=0.
- Reset asserted mid-frame returns all state to the reset values immediately (asynchronously). The first frame after reset displays blank in every position.

## Timing
- digit_o, an_o, frame_o and blink_phase_o are registered. Each reflects the counter/shadow state of the previous cycle, giving a fixed one-cycle latency.
- frame_o is high for exactly one cycle: the cycle after the fb edge, i.e. coincident with the first output cycle of slot 0 of the new frame.
- Shadow load and the k wrap happen on the same edge, so slot 0 of the new frame already shows the new inputs.
- The blink toggle takes effect from slot 0 of the frame after the BLINK_FRAMES-th fb.
- Frame length = 16*SLOT_STEP*NDIG cycles. Blink half-period = BLINK_FRAMES frames.
- Changing bright mid-frame has no effect until the next fb.
- There is no handshake. Inputs are sampled only at fb and may change at any time.

## Test plan
Bench parameters: NDIG=4, SLOT_STEP=1, BLINK_FRAMES=2 (64-cycle frame), unless stated otherwise.

- Reset and first frame: release rst_n with digits_i=16'h1234, bright=15. Frame 0 shows digit_o=F and an_o stepping 0001->0010->0100->1000, 16 cycles each. Frame 1 shows 4,3,2,1 in positions 0..3. frame_o pulses at cycles 65 and 129.
- Shadowing: change digits_i from 16'h1234 to 16'h5678 at cycle 10 of a frame. The remainder of that frame still shows 4,3,2,1; the next frame shows 8,7,6,5.
- Separator priority: sep_mask=4'b0100, blink_all=1. Position 2 shows B in every frame. The other positions alternate digit (2 frames) / F (2 frames). blink_phase_o toggles every 2 frames.
- Edit blink: blink_mask=4'b0001, blink_all=0. Only position 0 alternates 4 / F every 2 frames; positions 1..3 stay constant.
- Brightness: bright=3. Within each 16-cycle slot, an_o is one-hot for 4 cycles (d=0..3) then 0 for 12. With bright=0, enabled for 1 cycle per slot.
- Async reset mid-frame: assert rst_n=0 at cycle 37 of a frame. an_o=0 and digit_o=F immediately, without waiting for a clk edge. After release, the blank-first-frame behaviour repeats and blink_phase_o=0.
